gpio_serial_loader: RTL and testbench
=====================================

// Module: gpio_serial_loader
// PURPOSE
//  Drives per-pad configuration into the two GPIO control shift chains that feed the user-project pad array.
//  Chain 1 serves pads 0..AREA1PADS-1. Chain 2 serves pads AREA1PADS..TOTAL_PADS-1.
//  On start, it reads each pad's config word from the housekeeping register file and shifts it out MSB-first on both chains in parallel.
//  It then pulses serial_load so every pad's control block applies its new mode (dm, oeb, inp_dis, ...).
// PARAMETERS
//  AREA1PADS   19  pads on chain 1 (pads 0..AREA1PADS-1)
//  TOTAL_PADS  38  total user pads; chain 2 length A2 = TOTAL_PADS-AREA1PADS
//  CFG_BITS    13  config word width per pad
//  CLK_DIV     2   serial half-period in wb_clk_i cycles (>=1)
// PORTS
//  wb_clk_i       in   1         system clock
//  wb_rstn_i      in   1         async active-low reset
//  start          in   1         1-cycle request to (re)load all pads
//  busy           out  1         high while a load sequence runs
//  done           out  1         1-cycle pulse when sequence completes
//  cfg_addr_1     out  6         pad index requested for chain 1
//  cfg_data_1     in   CFG_BITS  config word of pad cfg_addr_1 (combinational, same cycle)
//  cfg_addr_2     out  6         pad index requested for chain 2
//  cfg_data_2     in   CFG_BITS  config word of pad cfg_addr_2
//  serial_clock   out  1         shift clock to both chains
//  serial_load    out  1         apply strobe to both chains
//  serial_data_1  out  1         data into chain 1 (enters at pad 0, flows upward)
//  serial_data_2  out  1         data into chain 2 (enters at pad TOTAL_PADS-1, flows downward)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters 0. Reset is async and effective mid-sequence.
//   After a mid-sequence reset, no serial_load is issued and the chains keep partial data.
//  N = max(AREA1PADS, A2). Word counter k runs 0..N-1. Word index i = N-1-k.
//   Chain 1: if i<AREA1PADS, send pad i; else send CFG_BITS zeros (padding).
//   Chain 2: if i<A2, send pad TOTAL_PADS-1-i; else send zeros.
//   Net effect: the far-end pad is sent first, and the shorter chain's padding goes first and is shifted out past its end.
//  cfg_addr_x = pad index when valid, else 0.
//  FSM states: IDLE -> FETCH -> SHIFT -> (FETCH | LOAD) -> IDLE.
//  IDLE
//   - busy=0, serial_* = 0.
//   - start=1 -> FETCH with k=0. busy=1 from the next cycle.
//  FETCH (1 cycle)
//   - cfg_addr_x valid.
//   - At the clock edge: shift_reg_x <= cfg_data_x, or 0 if padding.
//  SHIFT
//   - CFG_BITS bits; each bit lasts 2*CLK_DIV cycles.
//   - First CLK_DIV cycles: serial_clock=0. Next CLK_DIV cycles: serial_clock=1.
//   - serial_data_x = shift_reg_x[CFG_BITS-1], stable for the whole bit.
//   - Shift left by 1 at the end of each bit.
//   - After the last bit: k<N-1 -> k++, go to FETCH; else go to LOAD.
//  LOAD
//   - serial_load=1 for CLK_DIV cycles, then 0 for CLK_DIV cycles.
//   - serial_clock=0 and serial_data_x=0 throughout.
//   - Then -> IDLE with done=1 for one cycle and busy=0.
//  Latency: cycle after start accepted to done = N*(1+2*CLK_DIV*CFG_BITS) + 2*CLK_DIV. Defaults: 1011 cycles.
//  start while busy: ignored, no queuing. start together with reset: reset wins.
//  serial_clock never glitches. Data never changes while serial_clock=1.
//  Counter widths: $clog2 of the maximum count, each at least 1 bit. Word counter wraps only via return to IDLE.
// TESTING
//  1 Reset: hold wb_rstn_i=0 -> busy, done, serial_*, cfg_addr_* all 0. Release with no start -> outputs stay 0.
//  2 Params TOTAL=4, A1=2, CFG_BITS=4, CLK_DIV=1, pads {0:4'h1, 1:4'h2, 2:4'h3, 3:4'h4}, pulse start.
//    -> Behavioural chain models on rising serial_clock + serial_load hold 1,2 (chain 1) and 3,4 (chain 2).
//    -> done exactly 2*(1+8)+2 = 20 cycles after start is accepted.
//  3 TOTAL=5, A1=2, CFG_BITS=4, CLK_DIV=1 -> chain 1 sends 4'h0 padding first, then pads 1 and 0.
//    -> Chain 2 sends pads 2, 3, 4 in that order, as observed on cfg_addr_2. Models end correct.
//  4 start pulsed at cycles 3 and 10 of a running sequence -> ignored. Exactly one serial_load pulse and one done.
//  5 Assert wb_rstn_i low mid-SHIFT -> all outputs 0 in the same cycle, no serial_load.
//    -> A fresh start then completes the full sequence with correct chain contents.
//  6 Defaults, random config words -> done 1011 cycles after start is accepted.
//    -> 13 serial_clock rising edges per word, 247 in total. All 38 pads match.

Source files
------------

// File: rtl/gpio_serial_loader.sv
// Serial loader for the two GPIO pad-control shift chains: fetches each pad's config
// word, shifts both chains MSB-first in parallel, then strobes serial_load.
module gpio_serial_loader #(
  parameter int AREA1PADS  = 19,
  parameter int TOTAL_PADS = 38,
  parameter int CFG_BITS   = 13,
  parameter int CLK_DIV    = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rstn_i,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [5:0]          cfg_addr_1,
  input  logic [CFG_BITS-1:0] cfg_data_1,
  output logic [5:0]          cfg_addr_2,
  input  logic [CFG_BITS-1:0] cfg_data_2,
  output logic                serial_clock,
  output logic                serial_load,
  output logic                serial_data_1,
  output logic                serial_data_2
);

  localparam int A2   = TOTAL_PADS - AREA1PADS;
  localparam int N    = (AREA1PADS > A2) ? AREA1PADS : A2;
  localparam int K_W  = (N > 1) ? $clog2(N) : 1;
  localparam int PH_W = $clog2(2 * CLK_DIV);
  localparam int B_W  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [K_W-1:0]  K_LAST  = K_W'(N - 1);
  localparam logic [K_W-1:0]  K_ONE   = K_W'(1);
  localparam logic [K_W-1:0]  K_ZERO  = K_W'(0);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV);
  localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
  localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
  localparam logic [B_W-1:0]  B_LAST  = B_W'(CFG_BITS - 1);
  localparam logic [B_W-1:0]  B_ONE   = B_W'(1);
  localparam logic [B_W-1:0]  B_ZERO  = B_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SHIFT = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  // Word index runs from the far end down so the far-end pad is sent first.
  function automatic int word_idx(input logic [K_W-1:0] k);
    return N - 1 - int'(k);
  endfunction

  function automatic logic pad1_valid(input logic [K_W-1:0] k);
    return word_idx(k) < AREA1PADS;
  endfunction

  function automatic logic pad2_valid(input logic [K_W-1:0] k);
    return word_idx(k) < A2;
  endfunction

  function automatic logic [5:0] addr1(input logic [K_W-1:0] k);
    return pad1_valid(k) ? 6'(word_idx(k)) : 6'd0;
  endfunction

  function automatic logic [5:0] addr2(input logic [K_W-1:0] k);
    return pad2_valid(k) ? 6'(TOTAL_PADS - 1 - word_idx(k)) : 6'd0;
  endfunction

  state_t              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic [B_W-1:0]      bit_q, bit_d;
  logic [CFG_BITS-1:0] sr1_q, sr1_d, sr2_q, sr2_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                sclk_q, sclk_d, sload_q, sload_d;
  logic                sd1_q, sd1_d, sd2_q, sd2_d;
  logic [5:0]          addr1_q, addr1_d, addr2_q, addr2_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          k_d     = K_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        sr1_d   = pad1_valid(k_q) ? cfg_data_1 : {CFG_BITS{1'b0}};
        sr2_d   = pad2_valid(k_q) ? cfg_data_2 : {CFG_BITS{1'b0}};
        ph_d    = PH_ZERO;
        bit_d   = B_ZERO;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d  = PH_ZERO;
          sr1_d = sr1_q << 1;
          sr2_d = sr2_q << 1;
          if (bit_q == B_LAST) begin
            bit_d = B_ZERO;
            if (k_q == K_LAST) begin
              state_d = S_LOAD;
            end else begin
              k_d     = k_q + K_ONE;
              state_d = S_FETCH;
            end
          end else begin
            bit_d = bit_q + B_ONE;
          end
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      S_LOAD: begin
        if (ph_q == PH_LAST) begin
          ph_d    = PH_ZERO;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they leave the flops glitch-free.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    sclk_d  = (state_d == S_SHIFT) && (ph_d >= PH_HALF);
    sload_d = (state_d == S_LOAD) && (ph_d < PH_HALF);
    sd1_d   = (state_d == S_SHIFT) ? sr1_d[CFG_BITS-1] : 1'b0;
    sd2_d   = (state_d == S_SHIFT) ? sr2_d[CFG_BITS-1] : 1'b0;
    addr1_d = (state_d == S_FETCH) ? addr1(k_d) : 6'd0;
    addr2_d = (state_d == S_FETCH) ? addr2(k_d) : 6'd0;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_q <= S_IDLE;
      k_q     <= K_ZERO;
      ph_q    <= PH_ZERO;
      bit_q   <= B_ZERO;
      sr1_q   <= {CFG_BITS{1'b0}};
      sr2_q   <= {CFG_BITS{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sload_q <= 1'b0;
      sd1_q   <= 1'b0;
      sd2_q   <= 1'b0;
      addr1_q <= 6'd0;
      addr2_q <= 6'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sload_q <= sload_d;
      sd1_q   <= sd1_d;
      sd2_q   <= sd2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign serial_clock  = sclk_q;
  assign serial_load   = sload_q;
  assign serial_data_1 = sd1_q;
  assign serial_data_2 = sd2_q;
  assign cfg_addr_1    = addr1_q;
  assign cfg_addr_2    = addr2_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Scoreboard bench for gpio_serial_loader: three parameter sets, behavioural pad-chain
// models, expected pad images and done times queued at start, checked by a monitor.
module tb_gpio_serial_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_blk
    localparam int TOT = (g == 0) ? 38 : ((g == 1) ? 4 : 5);
    localparam int A1  = (g == 0) ? 19 : 2;
    localparam int A2  = TOT - A1;
    localparam int CB  = (g == 0) ? 13 : 4;
    localparam int CD  = (g == 0) ? 2 : 1;
    localparam int N   = (A1 > A2) ? A1 : A2;
    localparam int LAT = N * (1 + 2 * CD * CB) + 2 * CD;

    logic          rst_n, start, busy, done, sclk, sload, sd1, sd2;
    logic [5:0]    a1, a2;
    logic [CB-1:0] d1, d2;
    logic [CB-1:0] pad_mem [TOT];
    bit            fin_b = 1'b0;

    assign d1 = pad_mem[a1];
    assign d2 = pad_mem[a2];

    gpio_serial_loader #(
      .AREA1PADS(A1), .TOTAL_PADS(TOT), .CFG_BITS(CB), .CLK_DIV(CD)
    ) u_dut (
      .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start), .busy(busy), .done(done),
      .cfg_addr_1(a1), .cfg_data_1(d1), .cfg_addr_2(a2), .cfg_data_2(d2),
      .serial_clock(sclk), .serial_load(sload),
      .serial_data_1(sd1), .serial_data_2(sd2)
    );

    // Physical chains: newest bit at position 0; pad p of chain 1 sits at [p*CB +: CB],
    // pad TOT-1-j of chain 2 sits at [j*CB +: CB].
    logic [A1*CB-1:0]  ch1 = '0;
    logic [A2*CB-1:0]  ch2 = '0;
    logic [TOT*CB-1:0] img_q [$];
    int                cyc_q [$];
    int   rise_cnt = 0, load_cnt = 0, done_cnt = 0, stab_err = 0;
    logic p_sclk = 1'b0, p_sload = 1'b0, p_sd1 = 1'b0, p_sd2 = 1'b0, chk_done = 1'b0;

    always @(negedge clk) begin
      if (!rst_n) begin
        rise_cnt = 0;
        p_sclk   = 1'b0;
        p_sload  = 1'b0;
        chk_done = 1'b0;
      end else begin
        if (chk_done) begin
          check($sformatf("b%0d_done_width", g), 64'(done), 64'd0);
          chk_done = 1'b0;
        end
        if (p_sclk && sclk && (sd1 !== p_sd1 || sd2 !== p_sd2)) stab_err++;
        if (sclk && !p_sclk) begin
          ch1 = {ch1[A1*CB-2:0], sd1};
          ch2 = {ch2[A2*CB-2:0], sd2};
          rise_cnt++;
        end
        if (sload && !p_sload) begin
          load_cnt++;
          if (img_q.size() == 0) begin
            check($sformatf("b%0d_unexpected_load", g), 64'd1, 64'd0);
          end else begin
            logic [TOT*CB-1:0] img;
            img = img_q.pop_front();
            for (int p = 0; p < A1; p++)
              check($sformatf("b%0d_chain1_pad%0d", g, p), 64'(ch1[p*CB +: CB]), 64'(img[p*CB +: CB]));
            for (int j = 0; j < A2; j++)
              check($sformatf("b%0d_chain2_pad%0d", g, TOT - 1 - j), 64'(ch2[j*CB +: CB]),
                    64'(img[(TOT-1-j)*CB +: CB]));
            check($sformatf("b%0d_sclk_rises", g), 64'(rise_cnt), 64'(N * CB));
            check($sformatf("b%0d_data_stable", g), 64'(stab_err), 64'd0);
            rise_cnt = 0;
          end
        end
        if (done) begin
          done_cnt++;
          if (cyc_q.size() == 0) begin
            check($sformatf("b%0d_unexpected_done", g), 64'd1, 64'd0);
          end else begin
            check($sformatf("b%0d_latency", g), 64'(cyc), 64'(cyc_q.pop_front()));
            check($sformatf("b%0d_busy_at_done", g), 64'(busy), 64'd0);
            chk_done = 1'b1;
          end
        end
        p_sclk  = sclk;
        p_sload = sload;
        p_sd1   = sd1;
        p_sd2   = sd2;
      end
    end

    task automatic issue();
      logic [TOT*CB-1:0] img;
      @(negedge clk);
      start = 1'b1;
      for (int p = 0; p < TOT; p++) img[p*CB +: CB] = pad_mem[p];
      img_q.push_back(img);
      cyc_q.push_back(cyc + 1 + LAT);
      @(negedge clk);
      start = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while (busy !== 1'b0 && t < LAT + 100) begin
        @(negedge clk);
        t++;
      end
      if (busy !== 1'b0) check($sformatf("b%0d_timeout", g), 64'd1, 64'd0);
      repeat (3) @(negedge clk);
    endtask

    task automatic run_seq(input bit rnd, input bit ign);
      if (rnd) for (int p = 0; p < TOT; p++) pad_mem[p] = CB'($urandom);
      issue();
      if (ign) begin
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
    endtask

    task automatic abort_seq();
      int loads;
      for (int p = 0; p < TOT; p++) pad_mem[p] = CB'($urandom);
      issue();
      repeat (1 + 2 * CD * CB + 3) @(negedge clk);
      loads = load_cnt;
      #2 rst_n = 1'b0;
      #1;
      check($sformatf("b%0d_async_reset_outputs", g),
            64'({busy, done, sclk, sload, sd1, sd2, a1, a2}), 64'd0);
      img_q.delete();
      cyc_q.delete();
      repeat (3) @(negedge clk);
      check($sformatf("b%0d_reset_hold_outputs", g),
            64'({busy, done, sclk, sload, sd1, sd2, a1, a2}), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check($sformatf("b%0d_no_load_after_abort", g), 64'(load_cnt), 64'(loads));
    endtask

    initial begin
      rst_n = 1'b0;
      start = 1'b0;
      for (int p = 0; p < TOT; p++) pad_mem[p] = CB'(p + 1);
      repeat (3) @(negedge clk);
      check($sformatf("b%0d_reset_outputs", g),
            64'({busy, done, sclk, sload, sd1, sd2, a1, a2}), 64'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check($sformatf("b%0d_idle_outputs", g),
            64'({busy, done, sclk, sload, sd1, sd2, a1, a2}), 64'd0);
      run_seq(1'b0, 1'b0);
      run_seq(1'b1, 1'b1);
      abort_seq();
      run_seq(1'b1, 1'b0);
      check($sformatf("b%0d_load_count", g), 64'(load_cnt), 64'd3);
      check($sformatf("b%0d_done_count", g), 64'(done_cnt), 64'd3);
      fin_b = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_blk[0].fin_b && g_blk[1].fin_b && g_blk[2].fin_b) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(g_blk[0].fin_b && g_blk[1].fin_b && g_blk[2].fin_b))
      check("global_timeout", 64'd1, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
